// File: rtl/note_judge.sv
// note_judge: judges DFJK key presses against per-lane chart note queues, evaluating every lane once per video frame.
// Latency: a scan takes 3*LANES+1 cycles from the new_frame edge until busy is low again; results register the cycle after each lane's EVAL.
// Backpressure: note_ready drops while note_lane's queue is full, and upstream holds the note; new_frame during a scan is dropped and sets overrun.
//
// Ports: clk/reset_n (async active-low) | clear: synchronous restart
//        new_frame, DFJK, un_time: frame pulse, latched key levels, song time
//        note_valid/note_lane/note_time -> note_ready: note push handshake
//        score, combo, precise, judge_valid: judgement results | busy, overrun: scan status
// Optional: define NOTE_JUDGE_AUTOPLAY_EN to add the autoplay input. It judges every note perfect on its exact frame.

module note_judge_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  // The extra pointer MSB separates full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dat;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module note_judge #(
  parameter int LANES       = 4,
  parameter int TIME_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int PERFECT_WIN = 2,
  parameter int GOOD_WIN    = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     new_frame,
  input  logic [LANES-1:0]         DFJK,
  input  logic [TIME_W-1:0]        un_time,
  input  logic                     note_valid,
  input  logic [$clog2(LANES)-1:0] note_lane,
  input  logic [TIME_W-1:0]        note_time,
`ifdef NOTE_JUDGE_AUTOPLAY_EN
  input  logic                     autoplay,
`endif
  output logic                     note_ready,
  output logic [12:0]              score,
  output logic [3:0]               combo,
  output logic [1:0]               precise,
  output logic                     judge_valid,
  output logic                     busy,
  output logic                     overrun
);
  localparam int                LANE_W      = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);
  localparam logic [TIME_W:0]   PERFECT_LIM = (TIME_W + 1)'(PERFECT_WIN);
  localparam logic [TIME_W:0]   GOOD_LIM    = (TIME_W + 1)'(GOOD_WIN);
  localparam logic [12:0]       SCORE_MAX   = 13'h1FFF;
  localparam logic [3:0]        COMBO_MAX   = 4'hF;
  localparam logic [1:0]        J_NONE      = 2'b00;
  localparam logic [1:0]        J_PERFECT   = 2'b01;
  localparam logic [1:0]        J_GOOD      = 2'b10;
  localparam logic [1:0]        J_MISS      = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_NEXT} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LANES-1:0]    press_q, press_d;
  logic [LANES-1:0]    prev_keys_q, prev_keys_d;
  logic [TIME_W-1:0]   head_q, head_d;
  logic                head_empty_q, head_empty_d;
  logic [12:0]         score_q, score_d;
  logic [3:0]          combo_q, combo_d;
  logic [1:0]          precise_q, precise_d;
  logic                judge_vld_q, judge_vld_d;
  logic                overrun_q, overrun_d;

  logic [LANES-1:0]    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TIME_W-1:0]   fifo_head [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign fifo_push[g] = note_valid && (note_lane == LANE_W'(g));

    note_judge_fifo #(
      .W     (TIME_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .push     (fifo_push[g]),
      .push_dat (note_time),
      .pop      (fifo_pop[g]),
      .head_dat (fifo_head[g]),
      .full     (fifo_full[g]),
      .empty    (fifo_empty[g])
    );
  end

  assign note_ready  = !fifo_full[note_lane];
  assign score       = score_q;
  assign combo       = combo_q;
  assign precise     = precise_q;
  assign judge_valid = judge_vld_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;

  // Judgement datapath for the lane held in head_q; only acted on in EVAL.
  // diff is un_time - head modulo 2^TIME_W; its MSB is the sign, so song-time wrap needs no special handling.
  logic [TIME_W-1:0] diff;
  logic [TIME_W:0]   abs_diff;
  logic              press_eff;
  logic              hit_perfect, hit_good, is_late;
  logic [13:0]       score_sum;

  always_comb begin
    diff      = un_time - head_q;
    abs_diff  = diff[TIME_W-1] ? ({1'b0, ~diff} + (TIME_W + 1)'(1)) : {1'b0, diff};
    press_eff = press_q[lane_q];
`ifdef NOTE_JUDGE_AUTOPLAY_EN
    press_eff = press_eff || (autoplay && (diff == '0));
`endif
    hit_perfect = !head_empty_q && press_eff && (abs_diff <= PERFECT_LIM);
    hit_good    = !head_empty_q && press_eff && !hit_perfect && (abs_diff <= GOOD_LIM);
    // Late only when diff is positive and beyond the good window; early notes simply wait.
    is_late     = !head_empty_q && !hit_perfect && !hit_good && !diff[TIME_W-1] && (abs_diff > GOOD_LIM);
    score_sum   = {1'b0, score_q} + (hit_perfect ? 14'd2 : 14'd1);
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    press_d      = press_q;
    prev_keys_d  = prev_keys_q;
    head_d       = head_q;
    head_empty_d = head_empty_q;
    score_d      = score_q;
    combo_d      = combo_q;
    precise_d    = precise_q;
    judge_vld_d  = 1'b0;
    overrun_d    = overrun_q;
    fifo_pop     = '0;

    if (clear) begin
      state_d      = S_IDLE;
      lane_d       = '0;
      press_d      = '0;
      prev_keys_d  = '0;
      head_d       = '0;
      head_empty_d = 1'b1;
      score_d      = '0;
      combo_d      = '0;
      precise_d    = J_NONE;
      overrun_d    = 1'b0;
    end else begin
      if (new_frame && (state_q != S_IDLE)) begin
        overrun_d = 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (new_frame) begin
            state_d     = S_LOAD;
            lane_d      = '0;
            // Rising edges only: a held key never presses twice.
            press_d     = DFJK & ~prev_keys_q;
            prev_keys_d = DFJK;
          end
        end
        S_LOAD: begin
          head_d       = fifo_head[lane_q];
          head_empty_d = fifo_empty[lane_q];
          state_d      = S_EVAL;
        end
        S_EVAL: begin
          if (hit_perfect || hit_good) begin
            fifo_pop[lane_q] = 1'b1;
            judge_vld_d      = 1'b1;
            score_d          = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[12:0];
            combo_d          = (combo_q == COMBO_MAX) ? COMBO_MAX : combo_q + 4'd1;
            precise_d        = hit_perfect ? J_PERFECT : J_GOOD;
          end else if (is_late) begin
            fifo_pop[lane_q] = 1'b1;
            judge_vld_d      = 1'b1;
            combo_d          = '0;
            precise_d        = J_MISS;
          end
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (lane_q == LAST_LANE) begin
            state_d = S_IDLE;
          end else begin
            lane_d  = lane_q + LANE_W'(1);
            state_d = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      press_q      <= '0;
      prev_keys_q  <= '0;
      head_q       <= '0;
      head_empty_q <= 1'b1;
      score_q      <= '0;
      combo_q      <= '0;
      precise_q    <= J_NONE;
      judge_vld_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      press_q      <= press_d;
      prev_keys_q  <= prev_keys_d;
      head_q       <= head_d;
      head_empty_q <= head_empty_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      precise_q    <= precise_d;
      judge_vld_q  <= judge_vld_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: drives directed and random note/frame traffic into note_judge and compares against a queue-based reference model.
// Latency: each frame call waits for the scan to complete, bounded by a cycle budget.
// Backpressure: the model tracks per-lane queue occupancy to predict note_ready.

module tb_note_judge;
  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic        new_frame = 1'b0;
  logic [3:0]  DFJK = '0;
  logic [15:0] un_time = '0;
  logic        note_valid = 1'b0;
  logic [1:0]  note_lane = '0;
  logic [15:0] note_time = '0;
`ifdef NOTE_JUDGE_AUTOPLAY_EN
  logic        autoplay = 1'b0;
`endif
  logic        note_ready;
  logic [12:0] score;
  logic [3:0]  combo;
  logic [1:0]  precise;
  logic        judge_valid;
  logic        busy;
  logic        overrun;

  note_judge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .new_frame   (new_frame),
    .DFJK        (DFJK),
    .un_time     (un_time),
    .note_valid  (note_valid),
    .note_lane   (note_lane),
    .note_time   (note_time),
`ifdef NOTE_JUDGE_AUTOPLAY_EN
    .autoplay    (autoplay),
`endif
    .note_ready  (note_ready),
    .score       (score),
    .combo       (combo),
    .precise     (precise),
    .judge_valid (judge_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-lane note lists plus game counters.
  logic [15:0] mq [LANES][DEPTH];
  int          mcnt [LANES];
  int          m_score, m_combo, m_precise;
  logic [3:0]  m_prev;
  bit          m_overrun;

  task automatic check_eq(input string tag, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < LANES; l++) mcnt[l] = 0;
    m_score = 0; m_combo = 0; m_precise = 0; m_prev = '0; m_overrun = 1'b0;
  endfunction

  function automatic void model_pop(input int l);
    for (int k = 0; k < DEPTH - 1; k++) mq[l][k] = mq[l][k+1];
    mcnt[l]--;
  endfunction

  // One frame of judging straight from the game rules; returns the number of judgements.
  function automatic int model_frame(input logic [3:0] keys, input logic [15:0] t);
    logic [3:0] press;
    int n;
    press  = keys & ~m_prev;
    m_prev = keys;
    n = 0;
    for (int l = 0; l < LANES; l++) begin
      if (mcnt[l] > 0) begin
        logic [15:0] raw;
        int d, ad, verdict;
        raw = t - mq[l][0];
        d   = (raw >= 16'h8000) ? int'(raw) - 65536 : int'(raw);
        ad  = (d < 0) ? -d : d;
        verdict = 0;
        if (press[l] && ad <= 2)      begin verdict = 1; m_score += 2; m_combo++; end
        else if (press[l] && ad <= 6) begin verdict = 2; m_score += 1; m_combo++; end
        else if (d > 6)               begin verdict = 3; m_combo = 0; end
        if (verdict != 0) begin
          if (m_score > 8191) m_score = 8191;
          if (m_combo > 15) m_combo = 15;
          m_precise = verdict;
          model_pop(l);
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic push(input int lane, input logic [15:0] t);
    @(negedge clk);
    note_valid = 1'b1;
    note_lane  = lane[1:0];
    note_time  = t;
    #1;
    check_eq("push_ready", int'(note_ready), int'(mcnt[lane] < DEPTH));
    if (mcnt[lane] < DEPTH) begin
      mq[lane][mcnt[lane]] = t;
      mcnt[lane]++;
    end
    @(posedge clk);
    #1 note_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check_eq("clr_score", int'(score), 0);
    check_eq("clr_combo", int'(combo), 0);
    check_eq("clr_overrun", int'(overrun), 0);
  endtask

  // Runs one scan; extra_at > 0 pulses a second new_frame that many edges after the first.
  task automatic run_frame(input logic [3:0] keys, input logic [15:0] t, input int extra_at, output int jv);
    int cyc, exp_jv;
    bit done;
    exp_jv = model_frame(keys, t);
    if (extra_at > 0) m_overrun = 1'b1;
    @(negedge clk);
    DFJK = keys; un_time = t; new_frame = 1'b1;
    @(posedge clk);
    cyc = 1; jv = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      new_frame = 1'b0;
      if (judge_valid) jv++;
      if (!busy) done = 1'b1;
      else begin
        cyc++;
        if (extra_at > 0 && cyc == extra_at + 1) new_frame = 1'b1;
      end
    end
    new_frame = 1'b0;
    check_eq("scan_len", cyc, 3 * LANES + 1);
    check_eq("judge_cnt", jv, exp_jv);
    check_eq("score", int'(score), m_score);
    check_eq("combo", int'(combo), m_combo);
    check_eq("precise", int'(precise), m_precise);
    check_eq("overrun", int'(overrun), int'(m_overrun));
  endtask

  initial begin
    int jv;
    logic [15:0] t;
    model_reset();

    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_score", int'(score), 0);
    check_eq("rst_combo", int'(combo), 0);
    check_eq("rst_precise", int'(precise), 0);
    check_eq("rst_judge_valid", int'(judge_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    check_eq("rst_note_ready", int'(note_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Perfect hit on lane 0, then confirm the queue was emptied.
    push(0, 16'd100);
    run_frame(4'b0001, 16'd101, 0, jv);
    check_eq("t1_precise", int'(precise), 1);
    check_eq("t1_score", int'(score), 2);
    check_eq("t1_combo", int'(combo), 1);
    check_eq("t1_pulses", jv, 1);
    run_frame(4'b0000, 16'd101, 0, jv);
    run_frame(4'b0001, 16'd100, 0, jv);
    check_eq("t1_q0_empty", jv, 0);
    run_frame(4'b0000, 16'd100, 0, jv);

    // Good hit, then a late miss without a press.
    push(2, 16'd50);
    run_frame(4'b0100, 16'd55, 0, jv);
    check_eq("t2_good", int'(precise), 2);
    check_eq("t2_score", int'(score), 3);
    run_frame(4'b0000, 16'd55, 0, jv);
    push(2, 16'd50);
    run_frame(4'b0000, 16'd57, 0, jv);
    check_eq("t2_miss", int'(precise), 3);
    check_eq("t2_combo0", int'(combo), 0);
    run_frame(4'b0000, 16'd57, 0, jv);
    check_eq("t2_popped", jv, 0);

    // Fill lane 1; a held fifth note lands only after a pop.
    for (int k = 0; k < 4; k++) push(1, 16'd200);
    @(negedge clk);
    note_lane = 2'd1; #1;
    check_eq("t3_l1_full", int'(note_ready), 0);
    note_lane = 2'd3; #1;
    check_eq("t3_l3_ready", int'(note_ready), 1);
    note_lane = 2'd1; note_time = 16'd300; note_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t3_held", int'(note_ready), 0);
    run_frame(4'b0010, 16'd200, 0, jv);
    note_valid = 1'b0;
    mq[1][mcnt[1]] = 16'd300;
    mcnt[1]++;
    #1;
    check_eq("t3_refull", int'(note_ready), 0);
    do_clear();

    // Held key judges only on its first frame.
    push(3, 16'd400);
    push(3, 16'd401);
    run_frame(4'b1000, 16'd400, 0, jv);
    check_eq("t4_first", jv, 1);
    run_frame(4'b1000, 16'd401, 0, jv);
    check_eq("t4_held", jv, 0);
    run_frame(4'b0000, 16'd401, 0, jv);
    run_frame(4'b1000, 16'd401, 0, jv);
    run_frame(4'b0000, 16'd401, 0, jv);

    // Song time wrap: note at FFFE judged at 0001 is three ticks late.
    push(0, 16'hFFFE);
    run_frame(4'b0001, 16'h0001, 0, jv);
    check_eq("t5_wrap_good", int'(precise), 2);
    run_frame(4'b0000, 16'h0001, 0, jv);

    // Random traffic across the song-time wrap point.
    t = 16'hFFE0;
    for (int it = 0; it < 300; it++) begin
      int np;
      np = $urandom_range(0, 3);
      for (int k = 0; k < np; k++) push($urandom_range(0, 3), t + 16'($urandom_range(0, 16)) - 16'd4);
      run_frame(4'($urandom_range(0, 15)), t, 0, jv);
      t = t + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) do_clear();
    end

    // Saturation: 4100 perfect hits.
    do_clear();
    for (int it = 0; it < 1025; it++) begin
      for (int l = 0; l < LANES; l++) push(l, 16'd1000);
      run_frame(4'b1111, 16'd1000, 0, jv);
      run_frame(4'b0000, 16'd1000, 0, jv);
    end
    check_eq("sat_score", int'(score), 8191);
    check_eq("sat_combo", int'(combo), 15);

    // Second new_frame five edges into a scan.
    run_frame(4'b0000, 16'd1000, 5, jv);
    check_eq("ovr_flag", int'(overrun), 1);

    // Asynchronous reset mid-scan.
    push(0, 16'd2000);
    @(negedge clk);
    un_time = 16'd2000; new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mid_busy_pre", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", int'(busy), 0);
    check_eq("rst_mid_score", int'(score), 0);
    check_eq("rst_mid_combo", int'(combo), 0);
    check_eq("rst_mid_precise", int'(precise), 0);
    check_eq("rst_mid_jv", int'(judge_valid), 0);
    check_eq("rst_mid_overrun", int'(overrun), 0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    push(1, 16'd3000);
    run_frame(4'b0010, 16'd3000, 0, jv);
    check_eq("post_rst_perfect", int'(precise), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
